// File: rtl/decode_unit.sv
// RV32I decode stage: a small circular instruction queue feeding a registered
// decode output stage with a valid/ready handshake.
module decode_unit #(
  parameter int unsigned QDEPTH_LOG   = 2,
  parameter bit          ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [3:0]  dec_op,
  output logic [2:0]  dec_funct3,
  output logic        dec_funct7b5,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [31:0] dec_imm,
  output logic        dec_use_rs1,
  output logic        dec_use_rs2,
  output logic        dec_wr_rd,
  output logic        dec_illegal
);

  localparam int unsigned DEPTH = 1 << QDEPTH_LOG;
  localparam int unsigned PW    = QDEPTH_LOG;
  localparam int unsigned CW    = QDEPTH_LOG + 1;

  localparam logic [3:0] OP_LUI    = 4'd0;
  localparam logic [3:0] OP_AUIPC  = 4'd1;
  localparam logic [3:0] OP_JAL    = 4'd2;
  localparam logic [3:0] OP_JALR   = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_LOAD   = 4'd5;
  localparam logic [3:0] OP_STORE  = 4'd6;
  localparam logic [3:0] OP_OPIMM  = 4'd7;
  localparam logic [3:0] OP_OP     = 4'd8;
  localparam logic [3:0] OP_FENCE  = 4'd9;
  localparam logic [3:0] OP_SYSTEM = 4'd10;
  localparam logic [3:0] OP_ILL    = 4'd15;

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          enq;
  logic          deq;

  assign if_ready = (count != CW'(DEPTH));
  assign enq      = if_valid && if_ready;
  assign deq      = (count != '0) && (!dec_valid || dec_ready);

  // Combinational decode of the queue head
  logic [31:0] h_pc;
  logic [31:0] ins;
  logic [2:0]  f3;
  logic [3:0]  d_op;
  logic [2:0]  d_f3;
  logic        d_f7b5;
  logic [4:0]  d_rd;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [31:0] d_imm;
  logic        d_use1;
  logic        d_use2;
  logic        d_wr;
  logic        d_ill;
  logic        bad;

  assign h_pc = mem[rptr][63:32];
  assign ins  = mem[rptr][31:0];
  assign f3   = ins[14:12];

  always_comb begin
    d_op   = OP_ILL;
    d_f3   = f3;
    d_f7b5 = ins[30];
    d_rd   = ins[11:7];
    d_rs1  = ins[19:15];
    d_rs2  = ins[24:20];
    d_imm  = '0;
    d_use1 = 1'b0;
    d_use2 = 1'b0;
    d_wr   = 1'b0;
    d_ill  = 1'b0;
    bad    = 1'b0;
    case (ins[6:0])
      7'b0110111: begin d_op = OP_LUI;   d_imm = {ins[31:12], 12'b0}; d_wr = 1'b1; end
      7'b0010111: begin d_op = OP_AUIPC; d_imm = {ins[31:12], 12'b0}; d_wr = 1'b1; end
      7'b1101111: begin
        d_op  = OP_JAL;
        d_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        d_wr  = 1'b1;
      end
      7'b1100111: begin
        d_op = OP_JALR; d_imm = {{20{ins[31]}}, ins[31:20]};
        d_use1 = 1'b1; d_wr = 1'b1; bad = (f3 != 3'b000);
      end
      7'b1100011: begin
        d_op   = OP_BRANCH;
        d_imm  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        d_use1 = 1'b1; d_use2 = 1'b1;
        bad    = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0000011: begin
        d_op = OP_LOAD; d_imm = {{20{ins[31]}}, ins[31:20]};
        d_use1 = 1'b1; d_wr = 1'b1;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin
        d_op   = OP_STORE;
        d_imm  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        d_use1 = 1'b1; d_use2 = 1'b1;
        bad    = f3[2] || (f3 == 3'b011);
      end
      7'b0010011: begin
        d_op = OP_OPIMM; d_imm = {{20{ins[31]}}, ins[31:20]};
        d_use1 = 1'b1; d_wr = 1'b1;
      end
      7'b0110011: begin d_op = OP_OP; d_use1 = 1'b1; d_use2 = 1'b1; d_wr = 1'b1; end
      7'b0001111: begin d_op = OP_FENCE;  d_imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b1110011: begin d_op = OP_SYSTEM; d_imm = {{20{ins[31]}}, ins[31:20]}; d_wr = 1'b1; end
      default:    bad = 1'b1;
    endcase
    // Undecodable words either trap or collapse to addi x0, x0, 0
    if (bad) begin
      d_imm  = '0;
      d_use2 = 1'b0;
      d_wr   = 1'b0;
      if (ILLEGAL_TRAP) begin
        d_op   = OP_ILL;
        d_ill  = 1'b1;
        d_use1 = 1'b0;
      end else begin
        d_op   = OP_OPIMM;
        d_f3   = 3'b000;
        d_f7b5 = 1'b0;
        d_rd   = '0;
        d_rs1  = '0;
        d_rs2  = '0;
        d_use1 = 1'b1;
      end
    end
    if (d_rd == 5'd0) d_wr = 1'b0;
  end

  // Queue storage carries no reset; only pointers and count qualify its contents
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush && enq) mem[wptr] <= {if_pc, if_instr};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      dec_valid    <= 1'b0;
      dec_pc       <= '0;
      dec_op       <= '0;
      dec_funct3   <= '0;
      dec_funct7b5 <= 1'b0;
      dec_rd       <= '0;
      dec_rs1      <= '0;
      dec_rs2      <= '0;
      dec_imm      <= '0;
      dec_use_rs1  <= 1'b0;
      dec_use_rs2  <= 1'b0;
      dec_wr_rd    <= 1'b0;
      dec_illegal  <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        wptr      <= '0;
        rptr      <= '0;
        count     <= '0;
        dec_valid <= 1'b0;
      end else begin
        if (enq) wptr <= wptr + PW'(1);
        count <= count + CW'(enq) - CW'(deq);
        if (deq) begin
          rptr         <= rptr + PW'(1);
          dec_valid    <= 1'b1;
          dec_pc       <= h_pc;
          dec_op       <= d_op;
          dec_funct3   <= d_f3;
          dec_funct7b5 <= d_f7b5;
          dec_rd       <= d_rd;
          dec_rs1      <= d_rs1;
          dec_rs2      <= d_rs2;
          dec_imm      <= d_imm;
          dec_use_rs1  <= d_use1;
          dec_use_rs2  <= d_use2;
          dec_wr_rd    <= d_wr;
          dec_illegal  <= d_ill;
        end else if (dec_ready) begin
          dec_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_unit.sv
// Bench for decode_unit: trapping and NOP-substituting instances share stimulus
// and are compared every cycle against a queue-level reference model.
module tb_decode_unit;

  localparam int unsigned QL    = 2;
  localparam int unsigned DEPTH = 1 << QL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, flush, if_valid, dec_ready;
  logic [31:0] if_pc, if_instr;

  logic        if_ready1, dec_valid1, f7_1, rd_u1_1, u1_1, u2_1, wr1, ill1;
  logic [31:0] pc1, imm1;
  logic [3:0]  op1;
  logic [2:0]  f3_1;
  logic [4:0]  rd1, rs1_1, rs2_1;

  logic        if_ready0, dec_valid0, f7_0, u1_0, u2_0, wr0, ill0;
  logic [31:0] pc0, imm0;
  logic [3:0]  op0;
  logic [2:0]  f3_0;
  logic [4:0]  rd0, rs1_0, rs2_0;

  decode_unit #(.QDEPTH_LOG(QL), .ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready1), .if_pc(if_pc), .if_instr(if_instr),
    .dec_valid(dec_valid1), .dec_ready(dec_ready), .dec_pc(pc1), .dec_op(op1),
    .dec_funct3(f3_1), .dec_funct7b5(f7_1), .dec_rd(rd1), .dec_rs1(rs1_1),
    .dec_rs2(rs2_1), .dec_imm(imm1), .dec_use_rs1(u1_1), .dec_use_rs2(u2_1),
    .dec_wr_rd(wr1), .dec_illegal(ill1));

  decode_unit #(.QDEPTH_LOG(QL), .ILLEGAL_TRAP(1'b0)) dut_nop (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready0), .if_pc(if_pc), .if_instr(if_instr),
    .dec_valid(dec_valid0), .dec_ready(dec_ready), .dec_pc(pc0), .dec_op(op0),
    .dec_funct3(f3_0), .dec_funct7b5(f7_0), .dec_rd(rd0), .dec_rs1(rs1_0),
    .dec_rs2(rs2_0), .dec_imm(imm0), .dec_use_rs1(u1_0), .dec_use_rs2(u2_0),
    .dec_wr_rd(wr0), .dec_illegal(ill0));

  wire [90:0] b1 = {pc1, op1, f3_1, f7_1, rd1, rs1_1, rs2_1, imm1, u1_1, u2_1, wr1, ill1};
  wire [90:0] b0 = {pc0, op0, f3_0, f7_0, rd0, rs1_0, rs2_0, imm0, u1_0, u2_0, wr0, ill0};

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode written straight from the instruction-set rules
  function automatic logic [90:0] model(input logic [63:0] e, input bit trap);
    logic [31:0] pc, ins, imm;
    logic [3:0]  op;
    logic [2:0]  f3;
    bit          bad, u1, u2, wr;
    pc = e[63:32]; ins = e[31:0]; f3 = ins[14:12]; bad = 0; imm = 0; op = 4'd15;
    case (ins[6:0])
      7'h37: begin op = 4'd0; imm = ins & 32'hFFFFF000; end
      7'h17: begin op = 4'd1; imm = ins & 32'hFFFFF000; end
      7'h6F: begin op = 4'd2; imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) << 1; end
      7'h67: begin op = 4'd3; imm = 32'($signed(ins[31:20])); bad = (f3 != 0); end
      7'h63: begin op = 4'd4; imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) << 1;
                   bad = (f3 == 2) || (f3 == 3); end
      7'h03: begin op = 4'd5; imm = 32'($signed(ins[31:20])); bad = (f3 == 3) || (f3 >= 6); end
      7'h23: begin op = 4'd6; imm = 32'($signed({ins[31:25], ins[11:7]})); bad = (f3 > 2); end
      7'h13: begin op = 4'd7; imm = 32'($signed(ins[31:20])); end
      7'h33: op = 4'd8;
      7'h0F: begin op = 4'd9;  imm = 32'($signed(ins[31:20])); end
      7'h73: begin op = 4'd10; imm = 32'($signed(ins[31:20])); end
      default: bad = 1;
    endcase
    u1 = op inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    u2 = op inside {4'd4, 4'd6, 4'd8};
    wr = (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10}) && (ins[11:7] != 0);
    if (bad && trap)
      return {pc, 4'd15, f3, ins[30], ins[11:7], ins[19:15], ins[24:20], 32'd0, 4'b0001};
    if (bad)
      return {pc, 4'd7, 3'd0, 1'b0, 15'd0, 32'd0, 4'b1000};
    return {pc, op, f3, ins[30], ins[11:7], ins[19:15], ins[24:20], imm, u1, u2, wr, 1'b0};
  endfunction

  // Model state: entries waiting in the queue plus the presented output
  logic [63:0] q[$];
  bit          m_valid;
  bit          m_accepted;
  logic [90:0] m_b1, m_b0;

  task automatic model_update();
    bit do_enq, do_deq;
    logic [63:0] e;
    m_accepted = 0;
    if (rst) begin
      q.delete(); m_valid = 0; m_b1 = '0; m_b0 = '0;
    end else if (rdy) begin
      if (flush) begin
        q.delete(); m_valid = 0;
      end else begin
        do_enq = if_valid && (q.size() < DEPTH);
        do_deq = (q.size() > 0) && (!m_valid || dec_ready);
        if (do_deq) begin
          e = q.pop_front();
          m_b1 = model(e, 1'b1); m_b0 = model(e, 1'b0); m_valid = 1;
        end else if (dec_ready) begin
          m_valid = 0;
        end
        if (do_enq) begin
          q.push_back({if_pc, if_instr});
          m_accepted = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    check("if_ready_trap", 128'(if_ready1), 128'(q.size() != DEPTH));
    check("if_ready_nop", 128'(if_ready0), 128'(q.size() != DEPTH));
    check("dec_valid_trap", 128'(dec_valid1), 128'(m_valid));
    check("dec_valid_nop", 128'(dec_valid0), 128'(m_valid));
    check("fields_trap", 128'(b1), 128'(m_b1));
    check("fields_nop", 128'(b0), 128'(m_b0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  logic [6:0] opc_tab [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                               7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 15);
    if (sel < 11) r[6:0] = opc_tab[sel];
    else if (sel == 15) r = 32'h0;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  logic [31:0] words [3] = '{32'hFFF00093, 32'h00208463, 32'hFE20AE23};
  int acc, cnt, k;

  initial begin
    rst = 1; rdy = 0; flush = 0; if_valid = 0; dec_ready = 0;
    if_pc = 0; if_instr = 0;
    repeat (2) cycle();
    check("rst_if_ready", 128'(if_ready1), 128'(1));
    check("rst_dec_valid", 128'(dec_valid1), 128'(0));
    check("rst_fields", 128'(b1), 128'(0));

    // Single LUI: two-cycle latency
    rst = 0; rdy = 1; dec_ready = 1; if_valid = 1; if_pc = 0; if_instr = 32'h123450B7;
    cycle();
    check("lui_not_yet", 128'(dec_valid1), 128'(0));
    if_valid = 0;
    cycle();
    check("lui_valid", 128'(dec_valid1), 128'(1));
    check("lui_op", 128'(op1), 128'(0));
    check("lui_rd", 128'(rd1), 128'(1));
    check("lui_imm", 128'(imm1), 128'(32'h12345000));
    check("lui_wr", 128'(wr1), 128'(1));
    check("lui_use1", 128'(u1_1), 128'(0));
    cycle();

    // Back-to-back stream at full throughput
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin if_valid = 1; if_pc = 32'h100 + 32'(4 * i); if_instr = words[i]; end
      else if_valid = 0;
      cycle();
      if (i >= 1 && i <= 3) check("stream_valid", 128'(dec_valid1), 128'(1));
      if (i == 1) begin
        check("addi_op", 128'(op1), 128'(7));
        check("addi_imm", 128'(imm1), 128'(32'hFFFFFFFF));
        check("addi_rd", 128'(rd1), 128'(1));
      end else if (i == 2) begin
        check("beq_op", 128'(op1), 128'(4));
        check("beq_imm", 128'(imm1), 128'(32'h8));
        check("beq_rs1", 128'(rs1_1), 128'(1));
        check("beq_rs2", 128'(rs2_1), 128'(2));
        check("beq_wr", 128'(wr1), 128'(0));
      end else if (i == 3) begin
        check("sw_op", 128'(op1), 128'(6));
        check("sw_imm", 128'(imm1), 128'(32'hFFFFFFFC));
        check("sw_f3", 128'(f3_1), 128'(2));
        check("sw_use2", 128'(u2_1), 128'(1));
      end
    end

    // Stalled consumer: queue plus output register absorb exactly five
    rst = 1; cycle(); rst = 0;
    dec_ready = 0; if_valid = 1; acc = 0;
    for (int i = 0; i < 8; i++) begin
      if_pc = 32'h200 + 32'(4 * acc); if_instr = rand_instr();
      if (if_valid && if_ready1) acc++;
      cycle();
    end
    check("full_accepts", 128'(acc), 128'(5));
    check("full_if_ready", 128'(if_ready1), 128'(0));
    if_valid = 0; dec_ready = 1; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (dec_valid1 && dec_ready) cnt++;
      cycle();
    end
    check("drain_count", 128'(cnt), 128'(5));

    // Flush with full queue and an offered word
    dec_ready = 0; if_valid = 1;
    repeat (6) begin if_instr = rand_instr(); cycle(); end
    check("fill_full", 128'(if_ready1), 128'(0));
    flush = 1; if_instr = 32'h00500113;
    cycle();
    flush = 0; if_valid = 0;
    check("flush_valid", 128'(dec_valid1), 128'(0));
    check("flush_ready", 128'(if_ready1), 128'(1));
    dec_ready = 1; cnt = 0;
    repeat (3) begin cycle(); if (dec_valid1) cnt++; end
    check("flush_dropped", 128'(cnt), 128'(0));

    // All-zero word: trap vs NOP substitution
    if_valid = 1; if_pc = 32'h300; if_instr = 32'h0;
    cycle(); if_valid = 0; cycle();
    check("ill_op", 128'(op1), 128'(15));
    check("ill_flag", 128'(ill1), 128'(1));
    check("ill_wr", 128'(wr1), 128'(0));
    check("nop_op", 128'(op0), 128'(7));
    check("nop_rd", 128'(rd0), 128'(0));
    check("nop_imm", 128'(imm0), 128'(0));
    check("nop_ill", 128'(ill0), 128'(0));
    cycle();

    // Pause mid-stream; flush during the pause must be ignored
    k = 0; cnt = 0;
    for (int j = 0; j < 16; j++) begin
      rdy = !(j >= 5 && j <= 7); flush = !rdy;
      if_valid = (k < 8); if_pc = 32'h400 + 32'(4 * k);
      if_instr = 32'h00100093 + (32'(k) << 20);
      if (rdy && dec_valid1 && dec_ready) cnt++;
      cycle();
      if (m_accepted) k++;
      if (j >= 5 && j <= 7) check("pause_valid", 128'(dec_valid1), 128'(1));
    end
    check("pause_total", 128'(cnt), 128'(8));
    rdy = 1; flush = 0;

    // Randomized traffic
    if_valid = 0; if_pc = 32'h1000; if_instr = rand_instr();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      rdy       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      if_valid  = ($urandom_range(0, 9) < 7);
      dec_ready = ($urandom_range(0, 9) < 7);
      cycle();
      if (m_accepted) begin if_pc += 4; if_instr = rand_instr(); end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
